alu_sequencer: RTL and testbench

Multi-word arithmetic sequencer that acts as the initiator of the combinational N-bit ALU interface (operands, carry-in and command out; result, zero and carry-out back). It accepts one K·N-bit operation through a valid/ready request port and drives the ALU one N-bit slice per cycle, least-significant slice first, chaining carry between slices. It then returns the assembled wide result, final carry and aggregate zero through a valid/ready response port. It sits between the calculator control logic and the ALU instance.

---
 rtl/alu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives a combinational N-bit ALU one slice per cycle to
// execute a single K*N-bit operation, least-significant slice first. Carry is
// chained between slices for add/subtract. The assembled result, final carry
// and aggregate zero are returned through a valid/ready response port.
module alu_sequencer #(
    parameter int unsigned N    = 8,
    parameter int unsigned K    = 4,
    parameter int unsigned AC_N = 3,
    // ALU command codes; override with the values from the shared ALU header
    parameter logic [AC_N-1:0] AC_AD = AC_N'(1),
    parameter logic [AC_N-1:0] AC_SB = AC_N'(2),
    parameter logic [AC_N-1:0] AC_AN = AC_N'(3),
    parameter logic [AC_N-1:0] AC_OR = AC_N'(4),
    parameter logic [AC_N-1:0] AC_LS = AC_N'(5)
) (
    input  logic              clk,
    input  logic              rst_n,
    // request port
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AC_N-1:0]   req_op,
    input  logic [N*K-1:0]    req_a,
    input  logic [N*K-1:0]    req_b,
    input  logic              req_cin,
    // ALU initiator port
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic              alu_cin,
    output logic [AC_N-1:0]   alu_cs,
    input  logic [N-1:0]      alu_s,
    input  logic              alu_zero,
    input  logic              alu_cout,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N*K-1:0]    rsp_s,
    output logic              rsp_cout,
    output logic              rsp_zero,
    output logic              rsp_err
);

    localparam int unsigned W    = N * K;
    localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AC_N-1:0]   op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      s_q, s_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              op_ok;
    logic              chain_op;
    logic              last_slice;
    logic [31:0]       base;

    assign base       = N * 32'(cnt_q);
    assign last_slice = (cnt_q == CntW'(K - 1));
    assign op_ok      = (req_op == AC_AD) || (req_op == AC_SB) ||
                        (req_op == AC_AN) || (req_op == AC_OR);
    // Only add/subtract propagate carry between slices; logic ops force 0.
    assign chain_op   = (op_q == AC_AD) || (op_q == AC_SB);

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StDone);
    assign rsp_s      = s_q;
    assign rsp_cout   = cout_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

    // ALU drive: current slice while running, all-zero otherwise.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_cs  = '0;
        if (state_q == StRun) begin
            alu_a   = a_q[base +: N];
            alu_b   = b_q[base +: N];
            alu_cin = chain_op ? carry_q : 1'b0;
            alu_cs  = op_q;
        end
    end

    // Next-state and datapath updates for accept, per-slice step and response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    carry_d = req_cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    if (op_ok) begin
                        // Zero flag is an AND across slices, so start from 1.
                        zero_d  = 1'b1;
                        err_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                s_d[base +: N] = alu_s;
                zero_d         = zero_q & alu_zero;
                carry_d        = alu_cout;
                cout_d         = alu_cout;
                if (last_slice) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural N-bit ALU sits on the initiator
// port; each wide operation is checked against a whole-word reference model.
module tb_alu_sequencer;

    localparam int unsigned N    = 8;
    localparam int unsigned K    = 4;
    localparam int unsigned AC_N = 3;
    localparam int unsigned W    = N * K;

    localparam logic [AC_N-1:0] AC_AD = 3'd1;
    localparam logic [AC_N-1:0] AC_SB = 3'd2;
    localparam logic [AC_N-1:0] AC_AN = 3'd3;
    localparam logic [AC_N-1:0] AC_OR = 3'd4;
    localparam logic [AC_N-1:0] AC_LS = 3'd5;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [AC_N-1:0] req_op;
    logic [W-1:0]    req_a;
    logic [W-1:0]    req_b;
    logic            req_cin;
    logic [N-1:0]    alu_a;
    logic [N-1:0]    alu_b;
    logic            alu_cin;
    logic [AC_N-1:0] alu_cs;
    logic [N-1:0]    alu_s;
    logic            alu_zero;
    logic            alu_cout;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_s;
    logic            rsp_cout;
    logic            rsp_zero;
    logic            rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(
        .N    (N),
        .K    (K),
        .AC_N (AC_N),
        .AC_AD(AC_AD),
        .AC_SB(AC_SB),
        .AC_AN(AC_AN),
        .AC_OR(AC_OR),
        .AC_LS(AC_LS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_cs   (alu_cs),
        .alu_s    (alu_s),
        .alu_zero (alu_zero),
        .alu_cout (alu_cout),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_s    (rsp_s),
        .rsp_cout (rsp_cout),
        .rsp_zero (rsp_zero),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational N-bit ALU; subtract reports borrow on carry-out.
    always_comb begin
        alu_s    = '0;
        alu_cout = 1'b0;
        case (alu_cs)
            AC_AD: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
            AC_SB: {alu_cout, alu_s} = {1'b0, alu_a} - {1'b0, alu_b} - {{N{1'b0}}, alu_cin};
            AC_AN: alu_s = alu_a & alu_b;
            AC_OR: alu_s = alu_a | alu_b;
            AC_LS: alu_s = alu_a << 1;
            default: alu_s = '0;
        endcase
        alu_zero = (alu_s == '0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word reference: result of the wide operation in one step.
    function automatic void ref_model(input logic [AC_N-1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic cin,
                                      output logic [W-1:0] s, output logic cout,
                                      output logic zero, output logic err);
        logic [W:0] t;
        t    = '0;
        err  = 1'b0;
        case (op)
            AC_AD: t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            AC_SB: t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            AC_AN: t = {1'b0, a & b};
            AC_OR: t = {1'b0, a | b};
            default: err = 1'b1;
        endcase
        s    = t[W-1:0];
        cout = t[W];
        zero = !err && (s == '0);
    endfunction

    // Carry (or borrow) into slice i, from the operation on the low i slices.
    function automatic logic carry_into(input logic [AC_N-1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic cin, input int i);
        logic [W-1:0] mask;
        logic [W:0]   t;
        mask = '1;
        mask = mask >> (W - i * N);
        if (op == AC_AD) begin
            t = {1'b0, a & mask} + {1'b0, b & mask} + {{W{1'b0}}, cin};
            return t[i * N];
        end else if (op == AC_SB) begin
            t = {1'b0, a & mask} - {1'b0, b & mask} - {{W{1'b0}}, cin};
            return t[W];
        end
        return 1'b0;
    endfunction

    // One full transaction: request, per-slice ALU drive, response with stall.
    task automatic do_op(input logic [AC_N-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input int stall);
        logic [W-1:0] es;
        logic         ec, ez, ee;
        int           waits;
        waits = 0;
        while (req_ready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        check_eq("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        @(posedge clk); #1;
        // Scramble request inputs so the sequencer must use latched copies.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        req_cin   = 1'($urandom);
        ref_model(op, a, b, cin, es, ec, ez, ee);
        if (!ee) begin
            for (int i = 0; i < int'(K); i++) begin
                check_eq("run_rsp_valid", 64'(rsp_valid), 64'(0));
                check_eq("run_req_ready", 64'(req_ready), 64'(0));
                check_eq("alu_a", 64'(alu_a), 64'(a[i * N +: N]));
                check_eq("alu_b", 64'(alu_b), 64'(b[i * N +: N]));
                check_eq("alu_cin", 64'(alu_cin), 64'(carry_into(op, a, b, cin, i)));
                check_eq("alu_cs", 64'(alu_cs), 64'(op));
                @(posedge clk); #1;
            end
        end else begin
            check_eq("err_alu_cs", 64'(alu_cs), 64'(0));
            check_eq("err_alu_a", 64'(alu_a), 64'(0));
            check_eq("err_alu_b", 64'(alu_b), 64'(0));
        end
        check_eq("rsp_valid", 64'(rsp_valid), 64'(1));
        check_eq("rsp_s", 64'(rsp_s), 64'(es));
        check_eq("rsp_cout", 64'(rsp_cout), 64'(ec));
        check_eq("rsp_zero", 64'(rsp_zero), 64'(ez));
        check_eq("rsp_err", 64'(rsp_err), 64'(ee));
        // Stall with a competing request pending; nothing may move.
        rsp_ready = 1'b0;
        req_valid = (stall > 0);
        for (int j = 0; j < stall; j++) begin
            @(posedge clk); #1;
            check_eq("stall_rsp_valid", 64'(rsp_valid), 64'(1));
            check_eq("stall_req_ready", 64'(req_ready), 64'(0));
            check_eq("stall_rsp_s", 64'(rsp_s), 64'(es));
            check_eq("stall_rsp_cout", 64'(rsp_cout), 64'(ec));
            check_eq("stall_rsp_zero", 64'(rsp_zero), 64'(ez));
            check_eq("stall_alu_cs", 64'(alu_cs), 64'(0));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("post_req_ready", 64'(req_ready), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check_eq({tag, "_rsp_s"}, 64'(rsp_s), 64'(0));
        check_eq({tag, "_rsp_cout"}, 64'(rsp_cout), 64'(0));
        check_eq({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(0));
        check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        check_eq({tag, "_alu_a"}, 64'(alu_a), 64'(0));
        check_eq({tag, "_alu_b"}, 64'(alu_b), 64'(0));
        check_eq({tag, "_alu_cin"}, 64'(alu_cin), 64'(0));
        check_eq({tag, "_alu_cs"}, 64'(alu_cs), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [AC_N-1:0] ops [8];
        ops = '{AC_AD, AC_SB, AC_AN, AC_OR, AC_LS, 3'd0, 3'd6, 3'd7};
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        rsp_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(AC_AD, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        do_op(AC_AD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(AC_AN, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 0);
        do_op(AC_SB, 32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        do_op(AC_LS, 32'h1234_5678, 32'h0000_0001, 1'b0, 1);
        do_op(AC_AD, 32'h1122_3344, 32'h0101_0101, 1'b1, 3);
        do_op(AC_OR, 32'h0F00_00F0, 32'h00F0_0F00, 1'b1, 0);

        // Abort an operation during slice 2 with an asynchronous reset.
        req_valid = 1'b1;
        req_op    = AC_AD;
        req_a     = 32'h1122_3344;
        req_b     = 32'h0101_0101;
        req_cin   = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("abort_running_cs", 64'(alu_cs), 64'(AC_AD));
        check_eq("abort_slice2_a", 64'(alu_a), 64'(8'h22));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        #10;
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            check_eq("abort_no_rsp", 64'(rsp_valid), 64'(0));
            check_eq("abort_ready", 64'(req_ready), 64'(1));
        end

        for (int n = 0; n < 40; n++) begin
            do_op(ops[$urandom_range(7)], $urandom, $urandom, 1'($urandom),
                  int'($urandom_range(3)));
        end
        // Edge operands: all-ones and all-zero words through add and subtract.
        do_op(AC_SB, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);
        do_op(AC_AD, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
